// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state encoding, line levels and frame sizing for the serial transmitter.
package uart_frame_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
    function automatic int FRAME_BITS(input int data_w);
        return data_w + 2;
    endfunction
endpackage

// File: rtl/uart_bit_tick.sv
// uart_bit_tick: bit-period divider; tick marks the last clk of each bit period.
module uart_bit_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be at least 1");
    end
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: start/data/stop serializer fed through a one-deep holding register.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              frame_done
);
    localparam int BW = $clog2(DATA_W) + 1;
    tx_state_t         state, state_n;
    logic [DATA_W-1:0] hold, shift, shift_n;
    logic [BW-1:0]     bit_idx, bit_idx_n;
    logic              hold_full, tick, accept, drain;
    assign tx_ready   = !hold_full;
    assign accept     = tx_valid && !hold_full;
    assign frame_done = (state == STOP) && tick;
    // a queued byte leaves the holding register from IDLE, or straight from the end of STOP
    assign drain      = hold_full && (state == IDLE || frame_done);
    uart_bit_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (drain && state == IDLE),
        .tick   (tick)
    );
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        if (drain) begin
            state_n = START;
            shift_n = hold;
        end else if (tick) begin
            case (state)
                START: begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
                DATA: begin
                    shift_n   = shift >> 1;
                    bit_idx_n = bit_idx + 1'b1;
                    state_n   = bit_idx == BW'(DATA_W - 1) ? STOP : DATA;
                end
                STOP:    state_n = IDLE;
                default: state_n = state;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift     <= '0;
            bit_idx   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx_serial <= LINE_IDLE;
            tx_busy   <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            bit_idx   <= bit_idx_n;
            tx_busy   <= state_n != IDLE;
            tx_serial <= state_n == START ? START_BIT :
                         state_n == DATA  ? shift_n[0] :
                         state_n == STOP  ? STOP_BIT : LINE_IDLE;
            if (accept) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (drain) begin
                hold_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: table-driven line checks plus a decoding scoreboard on the CLKS_PER_BIT=1 instance.
module tb_uart_frame_tx;
    import uart_frame_pkg::*;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] d1 = '0, d4 = '0;
    logic       v1 = 1'b0, v4 = 1'b0;
    logic       rdy1, ser1, bsy1, fd1;
    logic       rdy4, ser4, bsy4, fd4;
    int         n_chk = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    int         mon_k = 0;
    logic [9:0] fr;
    logic       in_f;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;
    vec_t       vecs[4];
    logic [7:0] bp[3];

    uart_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .reset_n(reset_n), .tx_data(d1), .tx_valid(v1),
        .tx_ready(rdy1), .tx_serial(ser1), .tx_busy(bsy1), .frame_done(fd1)
    );
    uart_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u4 (
        .clk(clk), .reset_n(reset_n), .tx_data(d4), .tx_valid(v4),
        .tx_ready(rdy4), .tx_serial(ser4), .tx_busy(bsy4), .frame_done(fd4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic send1(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        d1 = d;
        v1 = 1'b1;
        while (!rdy1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail("send_ready_timeout");
        @(posedge clk);
        exp_q.push_back(d);
        #1;
        v1 = 1'b0;
        d1 = ~d;
    endtask

    task automatic wait_idle1();
        int t = 0;
        while ((bsy1 || !rdy1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail("idle_timeout");
    endtask

    // receiver model: decodes frames on the 1-clk-per-bit line and checks them against the scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            mon_k = 0;
        end else begin
            in_f = mon_k > 0 || ser1 == 1'b0;
            chk("mon_frame_done", fd1, in_f && mon_k == 9);
            if (in_f) begin
                fr[mon_k] = ser1;
                mon_k++;
                if (mon_k == 10) begin
                    mon_k = 0;
                    chk("mon_stop_bit", fr[9], 1);
                    if (exp_q.size() == 0) fail("mon_unexpected_frame");
                    else chk("mon_data", fr[8:1], exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        bp[0] = 8'h11;
        bp[1] = 8'h22;
        bp[2] = 8'h33;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_serial", ser1, 1);
        chk("rst_ready", rdy1, 1);
        chk("rst_busy", bsy1, 0);
        chk("rst_done", fd1, 0);
        chk("rst_serial4", ser4, 1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_line", {ser1, rdy1, bsy1, fd1}, 4'b1100);
        end

        for (int i = 0; i < 4; i++) begin
            wait_idle1();
            send1(vecs[i].data);
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("vec%0d_bit%0d", i, k), ser1, vecs[i].line[k]);
                chk($sformatf("vec%0d_busy%0d", i, k), bsy1, 1);
            end
            chk($sformatf("vec%0d_done", i), fd1, 1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_after", i), {ser1, bsy1}, 2'b10);
        end

        wait_idle1();
        send1(8'h3C);
        cnt = 0;
        fork
            begin
                for (int t = 0; t < 100; t++) begin
                    @(posedge clk);
                    #1;
                    if (!bsy1) break;
                    cnt++;
                end
            end
            begin
                repeat (3) @(posedge clk);
                send1(8'hC3);
                chk("b2b_ready_low", rdy1, 0);
            end
        join
        chk("b2b_contiguous_bits", cnt, 20);

        wait_idle1();
        @(negedge clk);
        v1 = 1'b1;
        d1 = bp[0];
        for (int i = 0; i < 3; i++) begin
            int t = 0;
            while (!rdy1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) fail("bp_ready_timeout");
            @(posedge clk);
            exp_q.push_back(d1);
            #1;
            chk("bp_ready_low", rdy1, 0);
            if (i < 2) d1 = bp[i+1];
            else v1 = 1'b0;
        end
        wait_idle1();
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 0);

        @(negedge clk);
        d4 = 8'h01;
        v4 = 1'b1;
        @(posedge clk);
        #1;
        v4 = 1'b0;
        d4 = 8'hFE;
        chk("cpb4_ready_low", rdy4, 0);
        for (int k = 0; k < FRAME_BITS(8) * 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("cpb4_line%0d", k), ser4, (k >= 4 && k < 8) || k >= 36);
            chk($sformatf("cpb4_done%0d", k), fd4, k == 39);
        end
        @(posedge clk);
        #1;
        chk("cpb4_after", {ser4, bsy4}, 2'b10);

        wait_idle1();
        send1(8'hFF);
        send1(8'h5A);
        repeat (4) @(posedge clk);
        #2;
        chk("mid_before_reset", ser1, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_async_serial", ser1, 1);
        chk("mid_async_busy", bsy1, 0);
        chk("mid_async_ready", rdy1, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            chk("post_reset_quiet", {ser1, bsy1, rdy1}, 3'b101);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
